// File: rtl/alu_mem_pipeline_pkg.sv
// Shared types and default sizing for the ALU/memory pipeline.
package alu_mem_pipeline_pkg;

  localparam int unsigned DW_DEFAULT        = 16;
  localparam int unsigned NREG_DEFAULT      = 16;
  localparam int unsigned MEM_DEPTH_DEFAULT = 256;

  // ALU operation codes; 12..15 are unassigned and produce zero.
  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_MUL   = 4'd2,
    FN_PASSA = 4'd3,
    FN_PASSB = 4'd4,
    FN_AND   = 4'd5,
    FN_OR    = 4'd6,
    FN_XOR   = 4'd7,
    FN_NEGA  = 4'd8,
    FN_NEGB  = 4'd9,
    FN_SRA   = 4'd10,
    FN_SLA   = 4'd11
  } func_e;

endpackage

// File: rtl/alu_mem_pipeline_alu.sv
// Combinational ALU; every result is truncated to DW bits.
module alu_mem_pipeline_alu
  import alu_mem_pipeline_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    func,
  output logic [DW-1:0] z
);

  logic [2*DW-1:0] prod;

  assign prod = a * b;

  // Operation decode; unassigned codes fall through to zero.
  always_comb begin
    z = '0;
    case (func)
      FN_ADD:   z = a + b;
      FN_SUB:   z = a - b;
      FN_MUL:   z = prod[DW-1:0];
      FN_PASSA: z = a;
      FN_PASSB: z = b;
      FN_AND:   z = a & b;
      FN_OR:    z = a | b;
      FN_XOR:   z = a ^ b;
      FN_NEGA:  z = '0 - a;
      FN_NEGB:  z = '0 - b;
      FN_SRA:   z = {a[DW-1], a[DW-1:1]};
      FN_SLA:   z = {a[DW-2:0], 1'b0};
      default:  z = '0;
    endcase
  end

endmodule

// File: rtl/alu_mem_pipeline.sv
// Four-stage register-read / ALU / register write-back / memory store
// pipeline with operand forwarding, global hold and debug read ports.
module alu_mem_pipeline
  import alu_mem_pipeline_pkg::*;
#(
  parameter int unsigned DW        = DW_DEFAULT,
  parameter int unsigned NREG      = NREG_DEFAULT,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT,
  localparam int unsigned RW       = $clog2(NREG),
  localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          hold,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic [RW-1:0] rd,
  input  logic [3:0]    func,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] zout,
  output logic          zout_valid,
  input  logic [RW-1:0] dbg_reg_sel,
  output logic [DW-1:0] dbg_reg_data,
  input  logic [AW-1:0] dbg_mem_addr,
  output logic [DW-1:0] dbg_mem_data
);

  logic [DW-1:0] regbank [NREG];
  logic [DW-1:0] mem     [MEM_DEPTH];

  // Stage 1: operands and control
  logic          v1;
  logic [DW-1:0] a1, b1;
  logic [RW-1:0] rd1;
  logic [3:0]    func1;
  logic [AW-1:0] addr1;
  // Stage 2: result awaiting register write-back
  logic          v2;
  logic [DW-1:0] z2;
  logic [RW-1:0] rd2;
  logic [AW-1:0] addr2;
  // Stage 3: result awaiting memory store
  logic          v3;
  logic [DW-1:0] z3;
  logic [AW-1:0] addr3;

  logic          accept;
  logic [DW-1:0] alu_z;
  logic [DW-1:0] opa, opb;

  assign in_ready = !hold;
  assign accept   = in_valid && !hold;

  alu_mem_pipeline_alu #(.DW(DW)) u_alu (
    .a    (a1),
    .b    (b1),
    .func (func1),
    .z    (alu_z)
  );

  // Operand forwarding: youngest in-flight producer wins, then the bank.
  always_comb begin
    opa = regbank[rs1];
    opb = regbank[rs2];
    if (v1 && rd1 == rs1)      opa = alu_z;
    else if (v2 && rd2 == rs1) opa = z2;
    if (v1 && rd1 == rs2)      opb = alu_z;
    else if (v2 && rd2 == rs2) opb = z2;
  end

  // Stage registers and result output; hold freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; a1 <= '0; b1 <= '0; rd1 <= '0; func1 <= '0; addr1 <= '0;
      v2 <= 1'b0; z2 <= '0; rd2 <= '0; addr2 <= '0;
      v3 <= 1'b0; z3 <= '0; addr3 <= '0;
      zout       <= '0;
      zout_valid <= 1'b0;
    end else if (!hold) begin
      v1 <= accept;
      if (accept) begin
        a1    <= opa;
        b1    <= opb;
        rd1   <= rd;
        func1 <= func;
        addr1 <= addr;
      end
      v2    <= v1;
      z2    <= alu_z;
      rd2   <= rd1;
      addr2 <= addr1;
      v3    <= v2;
      z3    <= z2;
      addr3 <= addr2;
      zout_valid <= v1;
      if (v1) zout <= alu_z;
    end
  end

  // Register bank write-back from stage 2; reset restores index values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NREG; k++) regbank[k] <= DW'(k);
    end else if (!hold && v2) begin
      regbank[rd2] <= z2;
    end
  end

  // Memory store from stage 3; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && !hold && v3) mem[addr3] <= z3;
  end

  assign dbg_reg_data = regbank[dbg_reg_sel];
  assign dbg_mem_data = mem[dbg_mem_addr];

endmodule
